// File: rtl/cpu_core_mc.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer with
// handshaked instruction and data buses, 16-entry register file (r0 hardwired to zero).
module cpu_core_mc #(
   parameter int unsigned DATA_W   = 16,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              pc_reset,
   input  logic              run,
   output logic              imem_req,
   output logic [15:0]       imem_addr,
   input  logic              imem_ready,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [15:0]       dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [15:0]       pc_out,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [15:0]       pc_r;
   logic [15:0]       ir_r;
   logic [15:0]       addr_r;
   logic [15:0]       next_pc_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [DATA_W-1:0] result_r;
   logic              wr_en_r;
   logic [3:0]        wr_idx_r;
   logic [DATA_W-1:0] rf_r [16];

   logic [3:0]        op_s;
   logic [3:0]        rs_s;
   logic [3:0]        rt_s;
   logic [3:0]        rd_s;
   logic [15:0]       pc_inc_s;
   logic [DATA_W-1:0] imm_sext_s;
   logic [DATA_W-1:0] sum_s;
   logic [DATA_W-1:0] alu_s;
   logic [15:0]       next_pc_s;
   logic              wr_en_s;
   logic [3:0]        wr_idx_s;

   assign op_s       = ir_r[15:12];
   assign rs_s       = ir_r[11:8];
   assign rt_s       = ir_r[7:4];
   assign rd_s       = ir_r[3:0];
   assign pc_inc_s   = pc_r + 16'd1;
   assign imm_sext_s = DATA_W'($signed(ir_r[3:0]));
   assign sum_s      = a_r + imm_sext_s;

   assign imem_addr  = pc_r;
   assign pc_out     = pc_r;
   assign dmem_addr  = addr_r;
   assign dmem_wdata = b_r;

   // State register
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (run && imem_ready) state_next_s = S_DECODE;
            else                   state_next_s = S_FETCH;
         end
         S_DECODE: state_next_s = S_EXEC;
         S_EXEC: begin
            if (op_s == 4'h9 || op_s == 4'hA) state_next_s = S_MEM;
            else if (op_s == 4'hF)            state_next_s = S_HALT;
            else                              state_next_s = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) state_next_s = S_WB;
            else            state_next_s = S_MEM;
         end
         S_WB:    state_next_s = S_FETCH;
         S_HALT:  state_next_s = S_HALT;
         default: state_next_s = S_FETCH;
      endcase
   end

   // Bus strobes and status; imem_req is masked by reset because reset forces FETCH
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
      case (state_r)
         S_FETCH: imem_req = run & ~pc_reset;
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op_s == 4'hA);
         end
         S_WB:    retire = 1'b1;
         S_HALT:  halted = 1'b1;
         default: imem_req = 1'b0;
      endcase
   end

   // ALU, branch target and writeback selection for the instruction in IR
   always_comb begin
      alu_s     = '0;
      next_pc_s = pc_inc_s;
      wr_en_s   = 1'b0;
      wr_idx_s  = rd_s;
      case (op_s)
         4'h0: begin alu_s = a_r + b_r; wr_en_s = 1'b1; end
         4'h1: begin alu_s = a_r - b_r; wr_en_s = 1'b1; end
         4'h2: begin alu_s = a_r & b_r; wr_en_s = 1'b1; end
         4'h3: begin alu_s = a_r | b_r; wr_en_s = 1'b1; end
         4'h4: begin alu_s = a_r ^ b_r; wr_en_s = 1'b1; end
         4'h5: begin alu_s = DATA_W'($signed(a_r) < $signed(b_r)); wr_en_s = 1'b1; end
         4'h6: begin alu_s = sum_s;            wr_en_s = 1'b1; wr_idx_s = rt_s; end
         4'h7: begin alu_s = a_r << ir_r[3:0]; wr_en_s = 1'b1; wr_idx_s = rt_s; end
         4'h8: begin alu_s = a_r >> ir_r[3:0]; wr_en_s = 1'b1; wr_idx_s = rt_s; end
         4'h9: begin wr_en_s = 1'b1; wr_idx_s = rt_s; end
         4'hA: wr_en_s = 1'b0;
         4'hB: begin
            if (a_r == b_r) next_pc_s = pc_inc_s + 16'($signed(ir_r[3:0]));
            else            next_pc_s = pc_inc_s;
         end
         4'hC: next_pc_s = {pc_inc_s[15:12], ir_r[11:0]};
         4'hD: begin
            next_pc_s = pc_inc_s + 16'($signed(ir_r[11:4]));
            alu_s     = DATA_W'(pc_inc_s);
            wr_en_s   = 1'b1;
         end
         4'hE:    next_pc_s = a_r[15:0];
         4'hF:    next_pc_s = pc_r;
         default: next_pc_s = pc_inc_s;
      endcase
   end

   // Datapath registers, each loaded in the state that owns it
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         pc_r      <= RESET_PC;
         ir_r      <= 16'h0000;
         addr_r    <= 16'h0000;
         next_pc_r <= 16'h0000;
         a_r       <= '0;
         b_r       <= '0;
         result_r  <= '0;
         wr_en_r   <= 1'b0;
         wr_idx_r  <= 4'h0;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (run && imem_ready) ir_r <= imem_rdata;
            end
            S_DECODE: begin
               a_r <= (rs_s == 4'h0) ? '0 : rf_r[rs_s];
               b_r <= (rt_s == 4'h0) ? '0 : rf_r[rt_s];
            end
            S_EXEC: begin
               result_r  <= alu_s;
               addr_r    <= sum_s[15:0];
               next_pc_r <= next_pc_s;
               wr_en_r   <= wr_en_s;
               wr_idx_r  <= wr_idx_s;
            end
            S_MEM: begin
               if (dmem_ready && op_s == 4'h9) result_r <= dmem_rdata;
            end
            S_WB:    pc_r <= next_pc_r;
            default: pc_r <= pc_r;
         endcase
      end
   end

   // Register file; entry 0 is never written so it always reads zero
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         for (int i = 0; i < 16; i++) rf_r[i] <= '0;
      end else if (state_r == S_WB && wr_en_r && wr_idx_r != 4'h0) begin
         rf_r[wr_idx_r] <= result_r;
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: directed programs plus random instructions checked against an
// instruction-level reference model; bus responders and checks live in one initial block.
module tb_cpu_core_mc;

   localparam int          DW  = 32;
   localparam logic [15:0] RPC = 16'h0040;

   logic          clk = 1'b0;
   logic          pc_reset;
   logic          run;
   logic          imem_req;
   logic [15:0]   imem_addr;
   logic          imem_ready;
   logic [15:0]   imem_rdata;
   logic          dmem_req;
   logic          dmem_we;
   logic [15:0]   dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ready;
   logic [DW-1:0] dmem_rdata;
   logic [15:0]   pc_out;
   logic          retire;
   logic          halted;

   always #5 clk = ~clk;

   cpu_core_mc #(.DATA_W(DW), .RESET_PC(RPC)) dut (
      .clk(clk), .pc_reset(pc_reset), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .pc_out(pc_out), .retire(retire), .halted(halted)
   );

   logic [15:0]   imem [65536];
   logic [DW-1:0] bmem [65536];   // memory as seen through the DUT's bus writes
   logic [DW-1:0] mmem [65536];   // memory as the reference model expects it
   logic [DW-1:0] mreg [16];
   logic [15:0]   mpc;
   logic [15:0]   m_addr;
   logic          m_we;
   logic [DW-1:0] m_wdata;
   logic [15:0]   last_fetch;
   logic [DW-1:0] last_wdata;
   int            passed = 0;
   int            total  = 0;
   int            cyc;
   int            ret_cyc;
   int            lat;

   always @(posedge clk or posedge pc_reset) begin
      if (pc_reset) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_reg(input logic [3:0] idx, input logic [DW-1:0] v);
      if (idx != 4'h0) mreg[idx] = v;
   endtask

   // Reference model: architectural effect of one instruction
   task automatic model_exec(input logic [15:0] ins, output bit is_mem, output bit is_halt);
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic [15:0]   pc1;
      a   = mreg[ins[11:8]];
      b   = mreg[ins[7:4]];
      imm = DW'($signed(ins[3:0]));
      pc1 = mpc + 16'd1;
      is_mem = 1'b0; is_halt = 1'b0; m_we = 1'b0; m_addr = 16'h0000; m_wdata = '0;
      mpc = pc1;
      case (ins[15:12])
         4'h0: set_reg(ins[3:0], a + b);
         4'h1: set_reg(ins[3:0], a - b);
         4'h2: set_reg(ins[3:0], a & b);
         4'h3: set_reg(ins[3:0], a | b);
         4'h4: set_reg(ins[3:0], a ^ b);
         4'h5: set_reg(ins[3:0], ($signed(a) < $signed(b)) ? DW'(1) : DW'(0));
         4'h6: set_reg(ins[7:4], a + imm);
         4'h7: set_reg(ins[7:4], a << ins[3:0]);
         4'h8: set_reg(ins[7:4], a >> ins[3:0]);
         4'h9: begin
            is_mem = 1'b1; m_addr = 16'(a + imm);
            set_reg(ins[7:4], mmem[m_addr]);
         end
         4'hA: begin
            is_mem = 1'b1; m_addr = 16'(a + imm); m_we = 1'b1; m_wdata = b;
            mmem[m_addr] = b;
         end
         4'hB: if (a == b) mpc = pc1 + 16'($signed(ins[3:0]));
         4'hC: mpc = {pc1[15:12], ins[11:0]};
         4'hD: begin
            set_reg(ins[3:0], DW'(pc1));
            mpc = pc1 + 16'($signed(ins[11:4]));
         end
         4'hE: mpc = a[15:0];
         default: begin is_halt = 1'b1; mpc = pc1 - 16'd1; end
      endcase
   endtask

   task automatic model_reset();
      mpc = RPC;
      for (int i = 0; i < 16; i++) mreg[i] = '0;
   endtask

   // Serve one instruction through both buses and check timing and bus content
   task automatic run_instr(input int iw, input int dw);
      logic [15:0]   ins;
      logic [15:0]   a0;
      logic [DW-1:0] w0;
      logic          we0;
      bit            is_mem;
      bit            is_halt;
      bit            hold_ok;
      int            n;
      int            exp_lat;
      n = 0;
      while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, mpc);
      chk("fetch_pc_out", pc_out, mpc);
      chk("fetch_excl", dmem_req, 0);
      last_fetch = imem_addr;
      ins = imem[imem_addr];
      model_exec(imem[mpc], is_mem, is_halt);
      exp_lat = 4 + iw + (is_mem ? 1 + dw : 0);
      lat = 1;
      hold_ok = 1'b1;
      imem_ready = 1'b0;
      for (int i = 0; i < iw; i++) begin
         imem_rdata = 16'($urandom);
         @(negedge clk); lat++;
         if (imem_req !== 1'b1 || imem_addr !== last_fetch) hold_ok = 1'b0;
      end
      if (iw > 0) chk("imem_hold", hold_ok, 1);
      imem_rdata = ins; imem_ready = 1'b1;
      @(negedge clk); lat++;
      imem_ready = 1'b0; imem_rdata = 16'($urandom);
      if (is_mem) begin
         n = 0;
         while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk); lat++; n++; end
         chk("dmem_req_lat", lat, 4 + iw);
         chk("dmem_addr", dmem_addr, m_addr);
         chk("dmem_we", dmem_we, m_we);
         if (m_we) chk("dmem_wdata", dmem_wdata, m_wdata);
         chk("mem_excl", imem_req, 0);
         a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we;
         hold_ok = 1'b1;
         for (int i = 0; i < dw; i++) begin
            dmem_rdata = DW'($urandom);
            @(negedge clk); lat++;
            if (dmem_req !== 1'b1 || dmem_addr !== a0 || dmem_wdata !== w0 ||
                dmem_we !== we0 || imem_req !== 1'b0) hold_ok = 1'b0;
         end
         if (dw > 0) chk("dmem_hold", hold_ok, 1);
         if (we0) begin bmem[a0] = w0; last_wdata = w0; end
         dmem_rdata = bmem[a0]; dmem_ready = 1'b1;
         @(negedge clk); lat++;
         dmem_ready = 1'b0; dmem_rdata = DW'($urandom);
      end
      n = 0;
      if (is_halt) begin
         while (halted !== 1'b1 && n < 20) begin @(negedge clk); lat++; n++; end
         chk("halt_lat", lat, 4 + iw);
      end else begin
         while (retire !== 1'b1 && n < 20) begin @(negedge clk); lat++; n++; end
         ret_cyc = cyc + 1;
         chk("retire_lat", lat, exp_lat);
         @(negedge clk);
         chk("retire_pulse", retire, 0);
      end
   endtask

   task automatic do_reset(input logic run_after);
      @(negedge clk);
      run = 1'b1; pc_reset = 1'b1; #1;
      chk("rst_imem_req", imem_req, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_retire", retire, 0);
      chk("rst_halted", halted, 0);
      chk("rst_pc", pc_out, RPC);
      @(negedge clk); @(negedge clk);
      pc_reset = 1'b0; run = run_after; #1;
      model_reset();
   endtask

   task automatic put(input logic [15:0] addr, input logic [15:0] ins);
      imem[addr] = ins;
   endtask

   initial begin
      bit          ok;
      int          n;
      logic [15:0] ri;
      pc_reset = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0000;
      dmem_ready = 1'b0; dmem_rdata = '0;
      last_fetch = 16'h0000; last_wdata = '0; ret_cyc = 0;
      for (int i = 0; i < 65536; i++) begin imem[i] = 16'hF000; bmem[i] = '0; mmem[i] = '0; end
      model_reset();

      // addi/addi/add, zero wait: retire at cycles 4, 8, 12, r3 = 7
      put(16'h0040, 16'h6015); put(16'h0041, 16'h612D); put(16'h0042, 16'h0123);
      put(16'h0043, 16'hA030);
      do_reset(1'b1);
      run_instr(0, 0); chk("retire_cyc1", ret_cyc, 4);
      run_instr(0, 0); chk("retire_cyc2", ret_cyc, 8);
      run_instr(0, 0); chk("retire_cyc3", ret_cyc, 12);
      run_instr(0, 0); chk("r3_value", last_wdata, 7);

      // str r1 / ldr r4 with three data wait cycles
      put(16'h0044, 16'hA014); put(16'h0045, 16'h9044); put(16'h0046, 16'hA045);
      run_instr(0, 3);
      run_instr(0, 3); chk("ldr_latency", lat, 8);
      run_instr(1, 0); chk("r4_value", last_wdata, 5);

      // PC wrap with beq and b at 16'hFFFF
      put(16'h0047, 16'h606F); put(16'h0048, 16'hE600); put(16'hFFFF, 16'hB11F);
      run_instr(0, 0); run_instr(0, 0);
      run_instr(0, 0); chk("beq_at_ffff_fetch", last_fetch, 16'hFFFF);
      put(16'hFFFF, 16'hC123);
      run_instr(2, 0); chk("beq_wrap_target", last_fetch, 16'hFFFF);
      put(16'h0123, 16'h6074); put(16'h0124, 16'h7772); put(16'h0125, 16'hE700);
      run_instr(0, 0); chk("b_wrap_target", last_fetch, 16'h0123);
      run_instr(0, 0); run_instr(0, 0);

      // bl with negative offset, then br back through the link register
      put(16'h0010, 16'hDFE5); put(16'h000F, 16'hE500); put(16'h0011, 16'hA056);
      run_instr(0, 0); chk("br_to_bl", last_fetch, 16'h0010);
      run_instr(0, 0); chk("bl_target", last_fetch, 16'h000F);
      run_instr(0, 0); chk("br_target", last_fetch, 16'h0011);
      chk("bl_link", last_wdata, 32'h0000_0011);

      // 32-bit overflow and signed compare
      put(16'h0012, 16'h601F); put(16'h0013, 16'h8111); put(16'h0014, 16'h6021);
      put(16'h0015, 16'h0123); put(16'h0016, 16'hA030); put(16'h0017, 16'h5304);
      put(16'h0018, 16'hA040); put(16'h0019, 16'hF000);
      for (int i = 0; i < 5; i++) run_instr(0, 0);
      chk("add_overflow", last_wdata, 32'h8000_0000);
      run_instr(0, 0); run_instr(0, 1);
      chk("slt_negative", last_wdata, 32'h0000_0001);

      // halt is terminal
      run_instr(0, 0);
      ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (imem_req !== 1'b0 || dmem_req !== 1'b0 || retire !== 1'b0 ||
             halted !== 1'b1 || pc_out !== 16'h0019) ok = 1'b0;
      end
      chk("halt_quiet_100", ok, 1);

      // no fetch while run is low after reset; fetch on the first cycle run rises
      do_reset(1'b0);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (imem_req !== 1'b0) ok = 1'b0; end
      chk("idle_no_req", ok, 1);
      run = 1'b1; #1;
      chk("first_req", imem_req, 1);
      chk("first_req_addr", imem_addr, RPC);

      // reset in the middle of a data-bus wait
      put(RPC, 16'hA014);
      imem_rdata = 16'hA014; imem_ready = 1'b1;
      @(negedge clk); imem_ready = 1'b0;
      n = 0;
      while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("midwait_req", dmem_req, 1);
      @(negedge clk); @(negedge clk);
      pc_reset = 1'b1; #1;
      chk("midwait_dmem_drop", dmem_req, 0);
      chk("midwait_we_drop", dmem_we, 0);
      chk("midwait_pc", pc_out, RPC);
      @(negedge clk); pc_reset = 1'b0; #1;
      model_reset();
      put(RPC, 16'h6015);
      run_instr(0, 0); chk("restart_fetch", last_fetch, RPC);

      // random instruction stream with random wait states
      for (int k = 0; k < 250; k++) begin
         ri = 16'($urandom);
         if (ri[15:12] == 4'hF) ri[15:12] = 4'($urandom_range(0, 14));
         imem[mpc] = ri;
         run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cpu_core_mc.md
CPU_CORE_MC -- requirements
Module: cpu_core_mc

Interface
REQ-001: The block SHALL have parameter DATA_W, default 16, legal range 16..32, giving the datapath and register width.
REQ-002: The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded at reset.
REQ-003: The block SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-004: The block SHALL have port pc_reset, input, 1 bit, the reset: asynchronous, active-high.
REQ-005: The block SHALL have port run, input, 1 bit, fetch enable; sampled only in FETCH.
REQ-006: The block SHALL have these instruction-bus ports: imem_req output 1; imem_addr output 16; imem_ready input 1; imem_rdata input 16.
REQ-007: The block SHALL have these data-bus ports: dmem_req output 1; dmem_we output 1; dmem_addr output 16; dmem_wdata output DATA_W; dmem_ready input 1; dmem_rdata input DATA_W.
REQ-008: The block SHALL have these status outputs: pc_out output 16 (current PC); retire output 1 (one-cycle pulse per completed instruction); halted output 1.

Function
REQ-009: Encoding SHALL be op[15:12], rs[11:8], rt[7:4], rd[3:0]; imm4 = [3:0], sign-extended to DATA_W unless stated otherwise.
REQ-010: Opcodes SHALL be 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed; result 1/0), 6 addi, 7 lsl, 8 lsr, 9 ldr, A str, B beq, C b, D bl, E br, F halt.
REQ-011: addi/lsl/lsr SHALL write rd=[7:4]; lsl/lsr shift by imm4 treated as unsigned 0..15, with logical zero fill.
REQ-012: ldr SHALL load rt <= mem[rs+imm4]; str SHALL store mem[rs+imm4] <= rt; dmem_addr SHALL be the low 16 bits of the sum.
REQ-013: Branch targets SHALL be: beq, if rs==rt then pc+1+imm4; b, {pc+1[15:12], [11:0]}; bl, pc+1+sext([11:4]) with rd=[3:0] <= zero-extended pc+1; br, pc <= low 16 bits of rs.
REQ-014: r0 SHALL always read 0; writes to r0 SHALL be discarded; all arithmetic SHALL wrap modulo 2^DATA_W; the PC SHALL wrap 16'hFFFF+1 -> 16'h0000.
REQ-015: The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016: In FETCH, with run=1, imem_req=1 and imem_addr=pc SHALL be held stable until imem_ready=1, when IR captures imem_rdata and the FSM goes to DECODE; with run=0, imem_req=0 and the FSM stays in FETCH.
REQ-017: DECODE SHALL latch operands and go to EXEC.
REQ-018: EXEC SHALL compute the ALU result or address; ldr/str SHALL go to MEM; halt SHALL go to HALT; all others SHALL go to WB.
REQ-019: In MEM, dmem_req=1, with dmem_we=1 for str, SHALL be held with dmem_addr/dmem_wdata stable until dmem_ready=1; ldr captures dmem_rdata; the FSM then goes to WB.
REQ-020: WB SHALL write the register file, update the PC (branch target or pc+1), pulse retire for 1 cycle and go to FETCH.
REQ-021: Latency with zero wait states (ready high on the first request cycle) SHALL be 4 cycles for ALU/branch instructions and 5 for ldr/str; each wait cycle SHALL add 1.
REQ-022: HALT SHALL be terminal until reset: halted=1, no requests issued, retire never pulses, PC frozen at the halt address.
REQ-023: Undecoded behaviour SHALL NOT exist: all 16 opcodes are defined.
REQ-024: dmem_req and imem_req SHALL never be asserted in the same cycle.

Reset
REQ-025: Asserting pc_reset at any time, including mid-wait on either bus, SHALL immediately force state FETCH, pc=RESET_PC, imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0, and all registers 0.
REQ-026: After reset deassertion, the first imem_req SHALL occur in the first cycle with run=1.

Verification
REQ-027: The bench SHALL cover: program addi r1,r0,5; addi r2,r1,-3; add r3,r1,r2 with zero wait -> r3=7, retire pulses at cycles 4, 8 and 12.
REQ-028: The bench SHALL cover: str r1 then ldr r4 at the same address with dmem_ready delayed 3 cycles -> dmem signals stable throughout, r4=5, ldr takes 8 cycles.
REQ-029: The bench SHALL cover: beq r1,r1,-1 at pc 16'hFFFF -> next fetch 16'hFFFF; b at 16'hFFFF -> next fetch {4'h0, imm12}.
REQ-030: The bench SHALL cover: bl with imm8=8'hFE at pc 16'h0010, rd=r5 -> r5=16'h0011, next fetch 16'h000F; then br r5 -> fetch 16'h0011.
REQ-031: The bench SHALL cover: DATA_W=32, add 32'h7FFFFFFF+1 -> 32'h80000000; slt of that value against r0 -> 1.
REQ-032: The bench SHALL cover: halt -> halted=1, no requests for 100 cycles; pc_reset pulse mid-dmem wait -> dmem_req drops at once and fetch restarts at RESET_PC.
